// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_pkg
//  Brief    : Shared definitions for the instruction-fetch stage: reset and
//             chip-enable levels, bus widths, NOP encoding, IF/ID action
//             encoding and a saturating counter helper.
//  Revision : 1.0  initial release
// ============================================================================
package if_stage_pkg;

   localparam logic        c_rst_enable    = 1'b1;
   localparam logic        c_rst_disable   = 1'b0;
   localparam logic        c_chip_enable   = 1'b1;
   localparam logic        c_chip_disable  = 1'b0;
   localparam int          c_inst_addr_w   = 16;
   localparam int          c_inst_w        = 16;
   localparam logic [15:0] c_nop           = 16'h0000;

   // Action taken by the IF/ID register on a clock edge
   typedef enum logic [1:0] {
      IFID_LOAD   = 2'd0,
      IFID_HOLD   = 2'd1,
      IFID_FLUSH  = 2'd2,
      IFID_BUBBLE = 2'd3
   } ifid_op_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Brief    : Program counter for the fetch stage. Selects the next fetch
//             address (branch redirect, stall hold or sequential +1) and
//             drives the synchronous instruction ROM.
//  Revision : 1.0  initial release
// ============================================================================
module pc_gen
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              stall_id,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              fetch_vld_o,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o
);

   logic [ADDR_W-1:0] r_pc;
   logic              r_started;
   logic              r_fetch_vld;
   logic [ADDR_W-1:0] w_pc_next;

   // Next fetch address: a branch from an unfrozen ID wins, then stall, then +1
   always_comb begin
      w_pc_next = r_pc + ADDR_W'(1);
      if (branch_flag_i && !stall_id) begin
         w_pc_next = branch_target_i;
      end else if (stall_if) begin
         w_pc_next = r_pc;
      end
   end

   // PC register; the first edge after reset only primes the ROM with RESET_PC,
   // so the ROM output and the PC stay aligned from then on
   always_ff @(posedge clk or posedge rst) begin
      if (rst == c_rst_enable) begin
         r_pc        <= RESET_PC;
         r_started   <= 1'b0;
         r_fetch_vld <= 1'b0;
      end else begin
         r_pc        <= r_started ? w_pc_next : RESET_PC;
         r_started   <= 1'b1;
         r_fetch_vld <= 1'b1;
      end
   end

   assign rom_ce_o    = (rst == c_rst_enable) ? c_chip_disable : c_chip_enable;
   assign rom_addr_o  = r_started ? w_pc_next : RESET_PC;
   assign pc_o        = r_pc;
   assign fetch_vld_o = r_fetch_vld;

endmodule : pc_gen
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Brief    : Instruction-fetch stage of the 16-bit 5-stage pipeline. Owns the
//             PC (via pc_gen) and the IF/ID pipeline register, handling
//             hazard stalls and ID-resolved branch redirects.
//  Options  : IF_PERF_CNT_EN - adds saturating fetch / bubble counters
//             (perf_fetch_o, perf_bubble_o).
//  Revision : 1.0  initial release
// ============================================================================
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                INST_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              stall_id,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [INST_W-1:0] rom_data_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_valid_o
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0]       perf_fetch_o,
   output logic [31:0]       perf_bubble_o
`endif
);

   localparam logic [INST_W-1:0] c_if_nop = INST_W'(c_nop);

   logic [ADDR_W-1:0] w_pc;
   logic              w_fetch_vld;
   ifid_op_e          w_op;

   logic [ADDR_W-1:0] r_id_pc;
   logic [INST_W-1:0] r_id_inst;
   logic              r_id_valid;

   pc_gen #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk             (clk),
      .rst             (rst),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .pc_o            (w_pc),
      .fetch_vld_o     (w_fetch_vld),
      .rom_ce_o        (rom_ce_o),
      .rom_addr_o      (rom_addr_o)
   );

   // IF/ID action: a frozen ID ignores branches (it re-asserts them later)
   always_comb begin
      w_op = IFID_LOAD;
      if (stall_id) begin
         w_op = IFID_HOLD;
      end else if (branch_flag_i) begin
         w_op = IFID_FLUSH;
      end else if (stall_if) begin
         w_op = IFID_BUBBLE;
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst == c_rst_enable) begin
         r_id_pc    <= '0;
         r_id_inst  <= c_if_nop;
         r_id_valid <= 1'b0;
      end else begin
         case (w_op)
            IFID_HOLD: begin
               r_id_pc    <= r_id_pc;
               r_id_inst  <= r_id_inst;
               r_id_valid <= r_id_valid;
            end
            IFID_FLUSH: begin
               r_id_pc    <= w_pc;
               r_id_inst  <= c_if_nop;
               r_id_valid <= 1'b0;
            end
            IFID_BUBBLE: begin
               r_id_pc    <= r_id_pc;
               r_id_inst  <= c_if_nop;
               r_id_valid <= 1'b0;
            end
            default: begin
               r_id_pc    <= w_pc;
               r_id_inst  <= w_fetch_vld ? rom_data_i : c_if_nop;
               r_id_valid <= w_fetch_vld;
            end
         endcase
      end
   end

   assign id_pc_o    = r_id_pc;
   assign id_inst_o  = r_id_inst;
   assign id_valid_o = r_id_valid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_bubble;
   logic        w_load_real;
   logic        w_load_bubble;

   assign w_load_real   = (w_op == IFID_LOAD) && w_fetch_vld;
   assign w_load_bubble = (w_op != IFID_HOLD) && !w_load_real;

   // Saturating counts of real instructions and bubbles entering IF/ID
   always_ff @(posedge clk or posedge rst) begin
      if (rst == c_rst_enable) begin
         r_perf_fetch  <= '0;
         r_perf_bubble <= '0;
      end else begin
         if (w_load_real) begin
            r_perf_fetch <= sat_inc32(r_perf_fetch);
         end
         if (w_load_bubble) begin
            r_perf_bubble <= sat_inc32(r_perf_bubble);
         end
      end
   end

   assign perf_fetch_o  = r_perf_fetch;
   assign perf_bubble_o = r_perf_bubble;
`endif

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Brief    : Self-checking bench for if_stage with a ROM model and an
//             instruction-flow reference model.
//  Options  : IF_PERF_CNT_EN - also checks the performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b1;
   logic        rst;
   logic        stall_if;
   logic        stall_id;
   logic        branch_flag;
   logic [15:0] branch_target;
   logic        rom_ce;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic [15:0] id_pc;
   logic [15:0] id_inst;
   logic        id_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_bubble;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic        m_started;
   logic        m_if_ready;
   logic [15:0] m_if_pc;
   logic        m_id_valid;
   logic [15:0] m_id_pc;
   logic [15:0] m_id_inst;
   int unsigned m_fetch;
   int unsigned m_bubble;

   if_stage #(
      .ADDR_W   (16),
      .INST_W   (16),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .branch_flag_i   (branch_flag),
      .branch_target_i (branch_target),
      .rom_ce_o        (rom_ce),
      .rom_addr_o      (rom_addr),
      .rom_data_i      (rom_data),
      .id_pc_o         (id_pc),
      .id_inst_o       (id_inst),
      .id_valid_o      (id_valid)
`ifdef IF_PERF_CNT_EN
     ,.perf_fetch_o    (perf_fetch),
      .perf_bubble_o   (perf_bubble)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      return 16'h1000 + a;
   endfunction

   // synchronous ROM: data for the address presented at an edge appears after it
   always @(posedge clk) begin
      if (rom_ce) rom_data <= rom_word(rom_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started  = 1'b0;
      m_if_ready = 1'b0;
      m_if_pc    = RESET_PC;
      m_id_valid = 1'b0;
      m_id_pc    = 16'h0000;
      m_id_inst  = 16'h0000;
      m_fetch    = 0;
      m_bubble   = 0;
   endtask

   // what the spec says happens at one clock edge with the current inputs
   task automatic model_edge();
      logic real_load;
      real_load = 1'b0;
      if (stall_id) begin
         // decode frozen: nothing moves
      end else if (branch_flag) begin
         m_id_valid = 1'b0; m_id_inst = 16'h0000; m_id_pc = m_if_pc; m_bubble++;
      end else if (stall_if) begin
         m_id_valid = 1'b0; m_id_inst = 16'h0000; m_bubble++;
      end else begin
         real_load  = m_if_ready;
         m_id_valid = m_if_ready;
         m_id_pc    = m_if_pc;
         m_id_inst  = m_if_ready ? rom_word(m_if_pc) : 16'h0000;
         if (real_load) m_fetch++; else m_bubble++;
      end
      if (!m_started) begin
         m_started = 1'b1; m_if_ready = 1'b1; m_if_pc = RESET_PC;
      end else if (branch_flag && !stall_id) begin
         m_if_pc = branch_target;
      end else if (!stall_if) begin
         m_if_pc = m_if_pc + 16'd1;
      end
   endtask

   function automatic logic [15:0] exp_rom_addr();
      if (!m_started) return RESET_PC;
      if (branch_flag && !stall_id) return branch_target;
      if (stall_if) return m_if_pc;
      return m_if_pc + 16'd1;
   endfunction

   // per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("id_valid", {31'd0, id_valid}, {31'd0, m_id_valid});
         check("id_inst", {16'd0, id_inst}, {16'd0, m_id_inst});
         if (m_id_valid) check("id_pc", {16'd0, id_pc}, {16'd0, m_id_pc});
         check("rom_ce", {31'd0, rom_ce}, 32'd1);
         check("rom_addr", {16'd0, rom_addr}, {16'd0, exp_rom_addr()});
`ifdef IF_PERF_CNT_EN
         check("perf_fetch", perf_fetch, m_fetch);
         check("perf_bubble", perf_bubble, m_bubble);
`endif
      end
   end

   task automatic step(input logic sif, input logic sid, input logic br, input logic [15:0] tgt);
      stall_if      = sif | sid;
      stall_id      = sid;
      branch_flag   = br;
      branch_target = tgt;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic pin(input string name, input logic v, input logic [15:0] pc, input logic [15:0] inst);
      check({name, "_valid"}, {31'd0, id_valid}, {31'd0, v});
      if (v) check({name, "_pc"}, {16'd0, id_pc}, {16'd0, pc});
      check({name, "_inst"}, {16'd0, id_inst}, {16'd0, inst});
   endtask

   initial begin
      rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0;
      branch_flag = 1'b0; branch_target = 16'h0000;
      model_reset();
      #185;
      check("rst_valid", {31'd0, id_valid}, 32'd0);
      check("rst_inst", {16'd0, id_inst}, 32'd0);
      check("rst_pc", {16'd0, id_pc}, 32'd0);
      check("rst_ce", {31'd0, rom_ce}, 32'd0);
      check("rst_addr", {16'd0, rom_addr}, {16'd0, RESET_PC});
      #10 rst = 1'b0;
`ifdef IF_PERF_CNT_EN
      check("rst_perf_fetch", perf_fetch, 32'd0);
      check("rst_perf_bubble", perf_bubble, 32'd0);
`endif
      // reset release: first real instruction after the 2nd edge
      step(0, 0, 0, 0);
      pin("edge1", 1'b0, 16'h0000, 16'h0000);
      step(0, 0, 0, 0);
      pin("first", 1'b1, 16'h0000, 16'h1000);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      pin("seq3", 1'b1, 16'h0003, 16'h1003);
      // load-use stall for two cycles
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      pin("held3", 1'b1, 16'h0003, 16'h1003);
      step(0, 0, 0, 0);
      pin("after_hold", 1'b1, 16'h0004, 16'h1004);
      step(0, 0, 0, 0);
      // IF-only stall: one bubble
      step(1, 0, 0, 0);
      pin("bubble", 1'b0, 16'h0000, 16'h0000);
      step(0, 0, 0, 0);
      pin("after_bubble", 1'b1, 16'h0006, 16'h1006);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      pin("seq8", 1'b1, 16'h0008, 16'h1008);
      // taken branch
      step(0, 0, 1, 16'h0040);
      pin("flush", 1'b0, 16'h0000, 16'h0000);
      step(0, 0, 0, 0);
      pin("target", 1'b1, 16'h0040, 16'h1040);
      // branch during ID freeze is ignored, re-asserted afterwards
      step(1, 1, 1, 16'h0080);
      pin("br_frozen", 1'b1, 16'h0040, 16'h1040);
      step(0, 0, 1, 16'h0080);
      pin("br_again", 1'b0, 16'h0000, 16'h0000);
      step(0, 0, 0, 0);
      pin("target2", 1'b1, 16'h0080, 16'h1080);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         int unsigned r;
         logic        sid, sif, br;
         r   = $urandom_range(0, 99);
         sid = (r < 10);
         sif = (r < 22);
         br  = ($urandom_range(0, 7) == 0);
         step(sif, sid, br, 16'($urandom));
      end
      // PC wrap-around
      step(0, 0, 1, 16'hFFFD);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      pin("pc_ffff", 1'b1, 16'hFFFF, 16'h0FFF);
      step(0, 0, 0, 0);
      pin("wrap", 1'b1, 16'h0000, 16'h1000);
      step(0, 0, 0, 0);
      // asynchronous reset between edges
      stall_if = 1'b0; stall_id = 1'b0; branch_flag = 1'b0; branch_target = 16'h0000;
      #2 rst = 1'b1;
      #1;
      check("async_valid", {31'd0, id_valid}, 32'd0);
      check("async_inst", {16'd0, id_inst}, 32'd0);
      check("async_ce", {31'd0, rom_ce}, 32'd0);
`ifdef IF_PERF_CNT_EN
      check("async_perf_fetch", perf_fetch, 32'd0);
      check("async_perf_bubble", perf_bubble, 32'd0);
`endif
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      step(0, 0, 0, 0);
      pin("restart1", 1'b0, 16'h0000, 16'h0000);
      step(0, 0, 0, 0);
      pin("restart2", 1'b1, RESET_PC, rom_word(RESET_PC));
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_if_stage
`default_nettype wire
